// File: rtl/mem_batch_arbiter.sv
// mem_batch_arbiter: snapshots a batch of per-core memory requests and serves
// the enabled cores one at a time, lowest index first, on a single-ported
// synchronous memory. Reads wait RD_LAT cycles for mem_rdata before the
// result is latched into the core's q slice.
module mem_batch_arbiter #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_rd,
    input  logic                        start_wr,
    input  logic [N_CORES-1:0]          en,
    input  logic [N_CORES*ADDR_W-1:0]   in_addr,
    input  logic [N_CORES*DATA_W-1:0]   in_data,
    output logic                        ready,
    output logic                        done,
    output logic [N_CORES*DATA_W-1:0]   q,
    output logic [N_CORES-1:0]          q_valid,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       op_wr_q, op_wr_d;
    logic [N_CORES-1:0]         pending_q, pending_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [N_CORES*ADDR_W-1:0]  snap_addr_q, snap_addr_d;
    logic [N_CORES*DATA_W-1:0]  snap_data_q, snap_data_d;
    logic                       ready_q, ready_d;
    logic                       done_q, done_d;
    logic [N_CORES*DATA_W-1:0]  q_q, q_d;
    logic [N_CORES-1:0]         q_valid_q, q_valid_d;
    logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]          mem_wdata_q, mem_wdata_d;
    logic                       mem_wren_q, mem_wren_d;

    logic [N_CORES-1:0]         idx_onehot;
    logic [N_CORES-1:0]         pend_left;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CORES-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Next-state and next-output logic; outputs are derived from the next
    // state so that they are registered yet line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        pending_d   = pending_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        snap_addr_d = snap_addr_q;
        snap_data_d = snap_data_q;
        q_d         = q_q;
        q_valid_d   = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        idx_onehot  = N_CORES'(1) << idx_q;
        pend_left   = pending_q & ~idx_onehot;

        case (state_q)
            S_IDLE: begin
                if (start_wr || start_rd) begin
                    op_wr_d     = start_wr;
                    pending_d   = en;
                    snap_addr_d = in_addr;
                    snap_data_d = in_data;
                    if (en == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = lowest_set(en);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (op_wr_q) begin
                    pending_d = pend_left;
                    if (pend_left != '0) idx_d = lowest_set(pend_left);
                    else                 state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    q_d[idx_q*DATA_W +: DATA_W] = mem_rdata;
                    q_valid_d = idx_onehot;
                    pending_d = pend_left;
                    if (pend_left != '0) begin
                        idx_d   = lowest_set(pend_left);
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d    = (state_d == S_IDLE);
        done_d     = (state_d == S_DONE);
        mem_wren_d = (state_d == S_ISSUE) && op_wr_d;
        if (state_d == S_ISSUE || state_d == S_WAIT)
            mem_addr_d = snap_addr_d[idx_d*ADDR_W +: ADDR_W];
        if (mem_wren_d)
            mem_wdata_d = snap_data_d[idx_d*DATA_W +: DATA_W];
    end

    // State, snapshot and output registers; reset aborts any batch at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_wr_q     <= 1'b0;
            pending_q   <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            snap_addr_q <= '0;
            snap_data_q <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            q_q         <= '0;
            q_valid_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            snap_addr_q <= snap_addr_d;
            snap_data_q <= snap_data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_mem_batch_arbiter.sv
// Bench for mem_batch_arbiter: 4 cores, 16-bit address/data, RD_LAT=2.
// A schedule model expands each accepted command into the expected per-cycle
// outputs; directed batches pin the model with literal timings and values,
// then a randomized phase runs against the same model.
module tb_mem_batch_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_rd, start_wr;
    logic [N-1:0]      en;
    logic [N*AW-1:0]   in_addr;
    logic [N*DW-1:0]   in_data;
    logic              ready, done, mem_wren;
    logic [N*DW-1:0]   q;
    logic [N-1:0]      q_valid;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_batch_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset), .start_rd(start_rd), .start_wr(start_wr),
        .en(en), .in_addr(in_addr), .in_data(in_data), .ready(ready), .done(done),
        .q(q), .q_valid(q_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 32'h20) return 16'h1234;
        if (a == 32'h30) return 16'hBEEF;
        return DW'(a * 7 + 32'h3c5a);
    endfunction

    // Memory: synchronous write, read data RL cycles after the address edge.
    logic [DW-1:0]      sim_mem [0:65535];
    logic [DW-1:0]      rd_pipe [0:RL-1];
    logic [AW+DW-1:0]   wr_q [$];
    bit                 mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) sim_mem[i] = init_val(i);
            mem_init = 1'b1;
        end
        rd_pipe[0] <= sim_mem[mem_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_wren) begin
            sim_mem[mem_addr] = mem_wdata;
            wr_q.push_back({mem_addr, mem_wdata});
        end
    end
    assign mem_rdata = rd_pipe[RL-1];

    // Reference model: expected outputs for each cycle as a schedule queue.
    typedef struct {
        bit            rdy, dn, wren, has_a, has_d, qv;
        int            qi;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] qd;
    } exp_t;

    exp_t            sched [$];
    exp_t            cur;
    logic [DW-1:0]   ref_mem [0:65535];
    bit              ref_init = 1'b0;
    bit              accept;
    logic [N*DW-1:0] m_q;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [N-1:0]    exp_qv;

    function automatic exp_t blank_entry(input bit rdy);
        exp_t e;
        e.rdy = rdy; e.dn = 0; e.wren = 0; e.has_a = 0; e.has_d = 0; e.qv = 0;
        e.qi = 0; e.a = '0; e.d = '0; e.qd = '0;
        return e;
    endfunction

    task automatic build_batch();
        exp_t          e;
        bit            carry = 0;
        int            ci = 0;
        logic [DW-1:0] cd = '0;
        logic [AW-1:0] a;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                a = in_addr[i*AW +: AW];
                if (start_wr) begin
                    e = blank_entry(0);
                    e.wren = 1; e.has_a = 1; e.a = a; e.has_d = 1; e.d = in_data[i*DW +: DW];
                    sched.push_back(e);
                end else begin
                    for (int j = 0; j <= RL; j++) begin
                        e = blank_entry(0);
                        e.has_a = 1; e.a = a;
                        if (carry) begin e.qv = 1; e.qi = ci; e.qd = cd; carry = 0; end
                        sched.push_back(e);
                    end
                    carry = 1; ci = i; cd = ref_mem[a];
                end
            end
        end
        e = blank_entry(0);
        e.dn = 1;
        if (carry) begin e.qv = 1; e.qi = ci; e.qd = cd; end
        sched.push_back(e);
    endtask

    // Compare process: every cycle, DUT outputs against the schedule head.
    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        accept = 0;
        if (reset) begin
            sched.delete();
            m_q = '0; m_addr = '0; m_wdata = '0;
            cur = blank_entry(1);
        end else if (sched.size() == 0) begin
            cur = blank_entry(1);
            accept = 1;
        end else begin
            cur = sched.pop_front();
        end
        if (cur.qv) m_q[cur.qi*DW +: DW] = cur.qd;
        if (cur.has_a) m_addr = cur.a;
        if (cur.has_d) m_wdata = cur.d;
        if (cur.wren) ref_mem[cur.a] = cur.d;
        exp_qv = cur.qv ? (N'(1) << cur.qi) : '0;
        check("ready", 64'(ready), 64'(cur.rdy));
        check("done", 64'(done), 64'(cur.dn));
        check("mem_wren", 64'(mem_wren), 64'(cur.wren));
        check("mem_addr", 64'(mem_addr), 64'(m_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        check("q_valid", 64'(q_valid), 64'(exp_qv));
        check("q", q, m_q);
        if (accept && (start_wr || start_rd)) build_batch();
    end

    int done_at, ready_at, qv1_at, qv3_at;

    task automatic go(input bit wr, input bit rd, input logic [N-1:0] e,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        @(posedge clk); #1;
        start_wr = wr; start_rd = rd; en = e; in_addr = a; in_data = d;
        wr_q.delete();
    endtask

    // Walks cycles 1.. after the command edge, recording when done/ready/q_valid appear.
    task automatic run_batch(input int hook);
        done_at = -1; ready_at = -1; qv1_at = -1; qv3_at = -1;
        for (int n = 1; n <= 100 && !(ready_at >= 0 && n > 4); n++) begin
            @(posedge clk); #1;
            if (n == 1) begin start_wr = 0; start_rd = 0; end
            if (hook == 1 && n == 2) begin
                in_addr = {4{16'hDEAD}}; in_data = {4{16'h5555}}; en = 4'b0001; start_wr = 1;
            end
            if (hook == 1 && n == 3) start_wr = 0;
            if (hook == 2 && n == 2) begin
                reset = 1; #1;
                check("rst_mid_ready", 64'(ready), 64'd1);
                check("rst_mid_wren", 64'(mem_wren), 64'd0);
                check("rst_mid_done", 64'(done), 64'd0);
            end
            if (hook == 2 && n == 3) reset = 0;
            @(negedge clk); #1;
            if (done && done_at < 0) done_at = n;
            if (ready && ready_at < 0) ready_at = n;
            if (q_valid[1] && qv1_at < 0) qv1_at = n;
            if (q_valid[3] && qv3_at < 0) qv3_at = n;
        end
        check("batch_timeout", 64'(ready_at > 0), 64'd1);
    endtask

    logic [N*AW-1:0]  fa;
    logic [N*DW-1:0]  fd;
    logic [AW+DW-1:0] wexp;
    int               extra_done;

    initial begin
        reset = 1; start_rd = 0; start_wr = 0; en = '0; in_addr = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Full write, 4 cores.
        for (int i = 0; i < N; i++) begin
            fa[i*AW +: AW] = AW'(16'h0100 + i);
            fd[i*DW +: DW] = DW'(16'hA000 + i);
        end
        go(1, 0, 4'b1111, fa, fd);
        run_batch(0);
        check("fw_done_at", 64'(done_at), 64'd5);
        check("fw_ready_at", 64'(ready_at), 64'd6);
        check("fw_nwr", 64'(wr_q.size()), 64'd4);
        for (int i = 0; i < N; i++) begin
            wexp = {AW'(16'h0100 + i), DW'(16'hA000 + i)};
            if (i < wr_q.size()) check("fw_pair", 64'(wr_q[i]), 64'(wexp));
        end

        // Sparse read, RD_LAT=2.
        go(0, 1, 4'b1010, {16'h0030, 16'h0055, 16'h0020, 16'h0066}, '0);
        run_batch(0);
        check("sr_done_at", 64'(done_at), 64'd7);
        check("sr_qv1_at", 64'(qv1_at), 64'd4);
        check("sr_qv3_at", 64'(qv3_at), 64'd7);
        check("sr_q1", 64'(q[16 +: 16]), 64'h1234);
        check("sr_q3", 64'(q[48 +: 16]), 64'hBEEF);
        check("sr_q0", 64'(q[0 +: 16]), 64'h0);
        check("sr_q2", 64'(q[32 +: 16]), 64'h0);

        // Asynchronous reset mid-cycle clears outputs at once.
        @(posedge clk); #3 reset = 1; #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", q, 64'd0);
        check("rst_wren", 64'(mem_wren), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        @(posedge clk); #1 reset = 0;

        // Empty mask.
        go(0, 1, 4'b0000, fa, fd);
        run_batch(0);
        check("em_done_at", 64'(done_at), 64'd1);
        check("em_ready_at", 64'(ready_at), 64'd2);
        check("em_nwr", 64'(wr_q.size()), 64'd0);

        // Snapshot: inputs and start_wr change mid-batch.
        for (int i = 0; i < N; i++) begin
            fa[i*AW +: AW] = AW'(16'h0200 + i);
            fd[i*DW +: DW] = DW'(16'hC000 + i);
        end
        go(1, 0, 4'b1111, fa, fd);
        run_batch(1);
        extra_done = 0;
        repeat (6) begin @(negedge clk); #1; if (done) extra_done++; end
        check("ss_nwr", 64'(wr_q.size()), 64'd4);
        check("ss_no_second", 64'(extra_done), 64'd0);
        for (int i = 0; i < N; i++) begin
            wexp = {AW'(16'h0200 + i), DW'(16'hC000 + i)};
            if (i < wr_q.size()) check("ss_pair", 64'(wr_q[i]), 64'(wexp));
        end

        // Both starts high: write wins.
        go(1, 1, 4'b0011, fa, fd);
        run_batch(0);
        check("bw_done_at", 64'(done_at), 64'd3);
        check("bw_nwr", 64'(wr_q.size()), 64'd2);
        check("bw_q", q, 64'd0);

        // Reset during the 2nd ISSUE of a 4-core write.
        for (int i = 0; i < N; i++) fa[i*AW +: AW] = AW'(16'h0300 + i);
        go(1, 0, 4'b1111, fa, fd);
        run_batch(2);
        check("rm_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) check("rm_pair", 64'(wr_q[0]), 64'({16'h0300, 16'hC000}));
        check("rm_ready", 64'(ready), 64'd1);
        go(1, 0, 4'b0110, fa, fd);
        run_batch(0);
        check("rm_next_done_at", 64'(done_at), 64'd3);
        check("rm_next_nwr", 64'(wr_q.size()), 64'd2);

        // Randomized phase against the schedule model.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            start_wr = ($urandom_range(0, 7) == 0);
            start_rd = ($urandom_range(0, 5) == 0);
            en       = N'($urandom);
            in_addr  = {$urandom, $urandom};
            in_data  = {$urandom, $urandom};
            reset    = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        reset = 0; start_wr = 0; start_rd = 0;
        repeat (20) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
